// File: rtl/snake_body_logic_if.sv
// Bundles the snake block's game-control, apple-placement and renderer read-port signals.
// The slave modport is the snake block; the master modport is the surrounding game logic.
interface snake_body_logic_if;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [9:0] apple_x;
    logic [9:0] apple_y;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic       eat_trigger;
    logic [4:0] snake_len;
    logic       game_over;
    logic [3:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_valid;

    modport master (
        output move_tick, dir_valid, dir_req, apple_x, apple_y, rd_idx,
        input  head_x, head_y, eat_trigger, snake_len, game_over, rd_x, rd_y, rd_valid
    );

    modport slave (
        input  move_tick, dir_valid, dir_req, apple_x, apple_y, rd_idx,
        output head_x, head_y, eat_trigger, snake_len, game_over, rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/snake_body_logic.sv
// Snake body: head movement, segment shift register, direction filtering,
// wall/self collision, apple-eat detection and a registered segment read port.
module snake_body_logic #(
    parameter int unsigned CELL     = 20,
    parameter int unsigned X_MAX    = 620,
    parameter int unsigned Y_MAX    = 460,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned START_X  = 300,
    parameter int unsigned START_Y  = 240
) (
    input logic                clk,
    input logic                rst,
    snake_body_logic_if.slave  bus
);

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirDown  = 2'd1;
    localparam logic [1:0] DirLeft  = 2'd2;
    localparam logic [1:0] DirRight = 2'd3;

    typedef enum logic [1:0] {StRun, StCheck, StDead} state_e;

    state_e     state_q, state_d;
    logic [9:0] seg_x_q [MAX_LEN];
    logic [9:0] seg_y_q [MAX_LEN];
    logic [1:0] cur_dir_q, next_dir_q;
    logic [4:0] len_q;
    logic       eat_q;
    logic [9:0] rd_x_q, rd_y_q;
    logic       rd_valid_q;

    logic [9:0] nh_x, nh_y;
    logic       wall_hit, self_hit;
    logic       do_step, do_eat, dir_en;

    // Wall test is made before the add/subtract so coordinates never wrap.
    always_comb begin
        nh_x     = seg_x_q[0];
        nh_y     = seg_y_q[0];
        wall_hit = 1'b0;
        unique case (next_dir_q)
            DirUp:    if (seg_y_q[0] == 10'd0) wall_hit = 1'b1;
                      else nh_y = seg_y_q[0] - 10'(CELL);
            DirDown:  if (seg_y_q[0] == 10'(Y_MAX)) wall_hit = 1'b1;
                      else nh_y = seg_y_q[0] + 10'(CELL);
            DirLeft:  if (seg_x_q[0] == 10'd0) wall_hit = 1'b1;
                      else nh_x = seg_x_q[0] - 10'(CELL);
            default:  if (seg_x_q[0] == 10'(X_MAX)) wall_hit = 1'b1;
                      else nh_x = seg_x_q[0] + 10'(CELL);
        endcase
        // The current tail vacates on this step, so only k <= len-2 can be hit.
        self_hit = 1'b0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((5'(k) + 5'd1 < len_q) && (nh_x == seg_x_q[k]) && (nh_y == seg_y_q[k])) begin
                self_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StRun;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (bus.move_tick) state_d = (wall_hit || self_hit) ? StDead : StCheck;
            StCheck: state_d = StRun;
            default: state_d = StDead;
        endcase
    end

    always_comb begin
        do_step = (state_q == StRun) && bus.move_tick && !(wall_hit || self_hit);
        do_eat  = (state_q == StCheck) && (seg_x_q[0] == bus.apple_x) &&
                  (seg_y_q[0] == bus.apple_y);
        // Reversal into the body is rejected against the direction actually travelled.
        dir_en  = (state_q != StDead) && bus.dir_valid && (bus.dir_req != (cur_dir_q ^ 2'b01));
        bus.game_over   = (state_q == StDead);
        bus.eat_trigger = eat_q;
        bus.head_x      = seg_x_q[0];
        bus.head_y      = seg_y_q[0];
        bus.snake_len   = len_q;
        bus.rd_x        = rd_x_q;
        bus.rd_y        = rd_y_q;
        bus.rd_valid    = rd_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (START_X >= i * CELL) ? 10'(START_X - i * CELL) : 10'd0;
                seg_y_q[i] <= 10'(START_Y);
            end
            cur_dir_q  <= DirRight;
            next_dir_q <= DirRight;
            len_q      <= 5'(INIT_LEN);
            eat_q      <= 1'b0;
            rd_x_q     <= 10'd0;
            rd_y_q     <= 10'd0;
            rd_valid_q <= 1'b0;
        end else begin
            if (do_step) begin
                seg_x_q[0] <= nh_x;
                seg_y_q[0] <= nh_y;
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                cur_dir_q <= next_dir_q;
            end
            if (dir_en) next_dir_q <= bus.dir_req;
            eat_q <= do_eat;
            if (do_eat && (len_q < 5'(MAX_LEN))) len_q <= len_q + 5'd1;
            rd_x_q     <= seg_x_q[bus.rd_idx];
            rd_y_q     <= seg_y_q[bus.rd_idx];
            rd_valid_q <= ({1'b0, bus.rd_idx} < len_q);
        end
    end

endmodule

// File: doc/snake_body_logic.md
Name: snake_body_logic

Overview:
- Owns the snake: head position, body segment shift register, direction control, wall and self collision, and apple-eat detection.
- Sits directly upstream of the apple placement block. It drives that block's eat_trigger, head_x and head_y, and receives apple_x and apple_y back.
- Exposes a registered segment read port for the VGA renderer.
- All positions are pixel coordinates on a 20-pixel grid.

Parameters:
- CELL, 20, grid step in pixels.
- X_MAX, 620, largest legal x (cells 0..31).
- Y_MAX, 460, largest legal y (cells 0..23).
- MAX_LEN, 16, segment storage depth. Fixed at 16 so that rd_idx is 4 bits and snake_len is 5 bits.
- INIT_LEN, 3, length after reset.
- START_X, 300, head x after reset.
- START_Y, 240, head y after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- move_tick  in  1  one-cycle pulse from the game-speed divider; requests one step.
- dir_valid  in  1  direction request strobe.
- dir_req  in  2  requested direction: 0=up, 1=down, 2=left, 3=right.
- apple_x  in  10  current apple x.
- apple_y  in  10  current apple y.
- head_x  out  10  head x (segment 0).
- head_y  out  10  head y.
- eat_trigger  out  1  one-cycle pulse when the head lands on the apple.
- snake_len  out  5  current length, range INIT_LEN..MAX_LEN.
- game_over  out  1  sticky death flag.
- rd_idx  in  4  renderer segment index.
- rd_x  out  10  x of segment rd_idx.
- rd_y  out  10  y of segment rd_idx.
- rd_valid  out  1  rd_idx < snake_len.

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-check or DEAD):
  - head = (START_X, START_Y).
  - seg[i] = (START_X - i*CELL, START_Y) for all i in 0..15; clamp at 0 if negative.
  - cur_dir = next_dir = right.
  - snake_len = INIT_LEN.
  - eat_trigger = 0, game_over = 0, rd_x = rd_y = 0, rd_valid = 0.
  - State = RUN.
- Direction handling:
  - On dir_valid, next_dir <= dir_req, unless dir_req is the opposite of cur_dir (up/down, left/right); in that case it is ignored.
  - A later dir_valid before the next step overwrites an earlier one.
  - cur_dir <= next_dir on each executed step.
- State RUN, move_tick=1 at cycle N:
  - nh = seg[0] plus CELL in next_dir.
  - Wall collision: x=0 moving left, x=X_MAX moving right, y=0 moving up, or y=Y_MAX moving down.
  - Self collision: nh equals seg[k] for any k in 0..snake_len-2. The tail seg[snake_len-1] is excluded because it vacates.
  - On any collision: state DEAD, game_over=1 at N+1, no segment changes.
  - Otherwise at N+1: seg[0]=nh and seg[i]=seg[i-1] for i in 1..15 (the whole array shifts, so seg[snake_len] keeps the old tail). State CHECK.
- State CHECK (one cycle, N+1):
  - If seg[0] == (apple_x, apple_y): eat_trigger=1 for exactly cycle N+2, and snake_len increments at N+2, saturating at MAX_LEN. At saturation eat_trigger still pulses but length holds.
  - Return to RUN at N+2.
  - move_tick during CHECK is dropped, not queued.
- State DEAD:
  - All outputs frozen, game_over=1, move_tick and dir_valid ignored.
  - Exits only on rst.
- eat_trigger is never high for more than one consecutive cycle, and is only asserted from CHECK.
- head_x/head_y always equal seg[0].
- Read port: one-cycle latency.
  - rd_x/rd_y <= seg[rd_idx]; rd_valid <= (rd_idx < snake_len).
  - The read port keeps operating in every state.
- No arithmetic wraps. Wall checks precede add/subtract, so coordinates stay within 0..X_MAX and 0..Y_MAX.

Test Plan:
- Reset, then 3 move_ticks spaced 4 cycles apart, apple at (100,100) -> head (320,240), (340,240), (360,240); eat_trigger stays 0; snake_len=3.
- From reset, apple placed at (320,240), one tick at cycle N -> head_x=320 at N+1; eat_trigger high only at N+2; snake_len=4 at N+2. Next tick: rd_idx=3 reads (280,240) with rd_valid=1.
- dir_valid dir_req=left while moving right -> ignored, head x still increments. Then up followed by down in the same step window -> down accepted (up set next_dir but cur_dir is still right), head y increases by 20.
- Head at x=620 moving right, tick -> game_over=1 next cycle, head frozen at 620; further ticks change nothing; rst clears game_over to 0 and restores head to (300,240).
- Grow to length 5, then steer down, left, up in successive ticks -> the third step lands on seg[3], giving game_over=1. A similar loop hitting only the exact tail cell (len 4) -> no death.
- Tick asserted in the cycle right after an executed tick (CHECK) -> ignored, head moves once. rst asserted during CHECK -> eat_trigger stays 0, all outputs return to reset values.
